bmu: RTL and testbench

BMU -- requirements
Module: bmu

---
 rtl/bmu.sv | 90 +++++++++
 tb/tb_bmu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bmu.sv
// Branch metric unit for a 4-state, rate-1/2, K=3 (7/5 octal) Viterbi decoder.
// Computes the eight registered Hamming-distance branch metrics one clock after each valid symbol pair.
module bmu (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [1:0] piso_data_i,
    output logic [1:0] bm_s0_s0_o,
    output logic [1:0] bm_s0_s2_o,
    output logic [1:0] bm_s1_s0_o,
    output logic [1:0] bm_s1_s2_o,
    output logic [1:0] bm_s2_s1_o,
    output logic [1:0] bm_s2_s3_o,
    output logic [1:0] bm_s3_s1_o,
    output logic [1:0] bm_s3_s3_o,
    output logic       valid_o
);

    localparam logic [1:0] EXP_S0_S0 = 2'b00;
    localparam logic [1:0] EXP_S0_S2 = 2'b11;
    localparam logic [1:0] EXP_S1_S0 = 2'b11;
    localparam logic [1:0] EXP_S1_S2 = 2'b00;
    localparam logic [1:0] EXP_S2_S1 = 2'b10;
    localparam logic [1:0] EXP_S2_S3 = 2'b01;
    localparam logic [1:0] EXP_S3_S1 = 2'b01;
    localparam logic [1:0] EXP_S3_S3 = 2'b10;

    // Two one-bit terms widened before the add, so the result tops out at 2.
    function automatic logic [1:0] hamming(input logic [1:0] r, input logic [1:0] e);
        logic [1:0] d;
        d = r ^ e;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    logic [1:0] bm_s0_s0_p0, bm_s0_s2_p0, bm_s1_s0_p0, bm_s1_s2_p0;
    logic [1:0] bm_s2_s1_p0, bm_s2_s3_p0, bm_s3_s1_p0, bm_s3_s3_p0;
    logic [1:0] bm_s0_s0_p1, bm_s0_s2_p1, bm_s1_s0_p1, bm_s1_s2_p1;
    logic [1:0] bm_s2_s1_p1, bm_s2_s3_p1, bm_s3_s1_p1, bm_s3_s3_p1;
    logic       vld_p1;

    // Stage p0: combinational distances against the hard-wired trellis symbols
    always_comb begin
        bm_s0_s0_p0 = hamming(piso_data_i, EXP_S0_S0);
        bm_s0_s2_p0 = hamming(piso_data_i, EXP_S0_S2);
        bm_s1_s0_p0 = hamming(piso_data_i, EXP_S1_S0);
        bm_s1_s2_p0 = hamming(piso_data_i, EXP_S1_S2);
        bm_s2_s1_p0 = hamming(piso_data_i, EXP_S2_S1);
        bm_s2_s3_p0 = hamming(piso_data_i, EXP_S2_S3);
        bm_s3_s1_p0 = hamming(piso_data_i, EXP_S3_S1);
        bm_s3_s3_p0 = hamming(piso_data_i, EXP_S3_S3);
    end

    // Stage p1: metric registers load only on valid input, so idle-cycle data never reaches them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            bm_s0_s0_p1 <= 2'd0;
            bm_s0_s2_p1 <= 2'd0;
            bm_s1_s0_p1 <= 2'd0;
            bm_s1_s2_p1 <= 2'd0;
            bm_s2_s1_p1 <= 2'd0;
            bm_s2_s3_p1 <= 2'd0;
            bm_s3_s1_p1 <= 2'd0;
            bm_s3_s3_p1 <= 2'd0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                bm_s0_s0_p1 <= bm_s0_s0_p0;
                bm_s0_s2_p1 <= bm_s0_s2_p0;
                bm_s1_s0_p1 <= bm_s1_s0_p0;
                bm_s1_s2_p1 <= bm_s1_s2_p0;
                bm_s2_s1_p1 <= bm_s2_s1_p0;
                bm_s2_s3_p1 <= bm_s2_s3_p0;
                bm_s3_s1_p1 <= bm_s3_s1_p0;
                bm_s3_s3_p1 <= bm_s3_s3_p0;
            end
        end
    end

    assign bm_s0_s0_o = bm_s0_s0_p1;
    assign bm_s0_s2_o = bm_s0_s2_p1;
    assign bm_s1_s0_o = bm_s1_s0_p1;
    assign bm_s1_s2_o = bm_s1_s2_p1;
    assign bm_s2_s1_o = bm_s2_s1_p1;
    assign bm_s2_s3_o = bm_s2_s3_p1;
    assign bm_s3_s1_o = bm_s3_s1_p1;
    assign bm_s3_s3_o = bm_s3_s3_p1;
    assign valid_o    = vld_p1;

endmodule

// File: tb/tb_bmu.sv
// Directed testbench for bmu: per-symbol metric tables, hold/reset behaviour and back-to-back streaming.
// Expected metric sets are hand-computed and packed {s00,s02,s10,s12,s21,s23,s31,s33}.
module tb_bmu;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [1:0] piso_data_i;
    logic [1:0] bm_s0_s0_o, bm_s0_s2_o, bm_s1_s0_o, bm_s1_s2_o;
    logic [1:0] bm_s2_s1_o, bm_s2_s3_o, bm_s3_s1_o, bm_s3_s3_o;
    logic       valid_o;
    logic [15:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [15:0] EXP_00 = 16'h2855; // 0,2,2,0,1,1,1,1
    localparam logic [15:0] EXP_11 = 16'h8255; // 2,0,0,2,1,1,1,1
    localparam logic [15:0] EXP_01 = 16'h5582; // 1,1,1,1,2,0,0,2
    localparam logic [15:0] EXP_10 = 16'h5528; // 1,1,1,1,0,2,2,0

    always #5 clk_i = ~clk_i;

    bmu dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .piso_data_i (piso_data_i),
        .bm_s0_s0_o  (bm_s0_s0_o),
        .bm_s0_s2_o  (bm_s0_s2_o),
        .bm_s1_s0_o  (bm_s1_s0_o),
        .bm_s1_s2_o  (bm_s1_s2_o),
        .bm_s2_s1_o  (bm_s2_s1_o),
        .bm_s2_s3_o  (bm_s2_s3_o),
        .bm_s3_s1_o  (bm_s3_s1_o),
        .bm_s3_s3_o  (bm_s3_s3_o),
        .valid_o     (valid_o)
    );

    assign obs = {bm_s0_s0_o, bm_s0_s2_o, bm_s1_s0_o, bm_s1_s2_o,
                  bm_s2_s1_o, bm_s2_s3_o, bm_s3_s1_o, bm_s3_s3_o};

    function automatic logic [15:0] exp_of(input logic [1:0] s);
        case (s)
            2'b00:   return EXP_00;
            2'b11:   return EXP_11;
            2'b01:   return EXP_01;
            default: return EXP_10;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1; valid_i = 1'b1; piso_data_i = 2'b11;
        tick();
        @(negedge clk_i);
        tick();
        n_total++;
        if (obs !== 16'h0000) $display("FAIL reset_bm actual=%h required=0000", obs);
        else n_pass++;
        n_total++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid actual=%b required=0", valid_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0; piso_data_i = 2'b00;
        tick();
        n_total++;
        if (valid_o !== 1'b0 || obs !== 16'h0000)
            $display("FAIL reset_idle actual=%b/%h required=0/0000", valid_o, obs);
        else n_pass++;
    endtask

    task automatic test_symbols();
        logic [1:0]  syms [4];
        logic [15:0] exps [4];
        syms = '{2'b00, 2'b11, 2'b01, 2'b10};
        exps = '{EXP_00, EXP_11, EXP_01, EXP_10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; piso_data_i = syms[i];
            tick();
            n_total++;
            if (obs !== exps[i] || valid_o !== 1'b1)
                $display("FAIL symbol_%b actual=%h/%b required=%h/1", syms[i], obs, valid_o, exps[i]);
            else n_pass++;
            @(negedge clk_i);
            valid_i = 1'b0;
            tick();
            n_total++;
            if (obs !== exps[i] || valid_o !== 1'b0)
                $display("FAIL idle_after_%b actual=%h/%b required=%h/0", syms[i], obs, valid_o, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold_reset();
        @(negedge clk_i);
        valid_i = 1'b1; piso_data_i = 2'b00;
        tick();
        @(negedge clk_i);
        valid_i = 1'b0; piso_data_i = 2'b11;
        tick();
        n_total++;
        if (obs !== EXP_00 || valid_o !== 1'b0)
            $display("FAIL hold_invalid actual=%h/%b required=%h/0", obs, valid_o, EXP_00);
        else n_pass++;
        @(negedge clk_i);
        piso_data_i = 2'bxz;
        tick();
        n_total++;
        if (obs !== EXP_00 || valid_o !== 1'b0)
            $display("FAIL hold_xz actual=%h/%b required=%h/0", obs, valid_o, EXP_00);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1; piso_data_i = 2'b11;
        tick();
        n_total++;
        if (obs !== 16'h0000 || valid_o !== 1'b0)
            $display("FAIL hold_then_reset actual=%h/%b required=0000/0", obs, valid_o);
        else n_pass++;
        // Mid-stream reset with valid asserted discards the symbol
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b1; piso_data_i = 2'b01;
        tick();
        @(negedge clk_i);
        rst_i = 1'b1; piso_data_i = 2'b10;
        tick();
        n_total++;
        if (obs !== 16'h0000 || valid_o !== 1'b0)
            $display("FAIL midstream_reset actual=%h/%b required=0000/0", obs, valid_o);
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; piso_data_i = 2'b10;
        tick();
        n_total++;
        if (obs !== EXP_10 || valid_o !== 1'b1)
            $display("FAIL first_after_reset actual=%h/%b required=%h/1", obs, valid_o, EXP_10);
        else n_pass++;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [8];
        seq = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; piso_data_i = seq[i];
            tick();
            n_total++;
            if (obs !== exp_of(seq[i]) || valid_o !== 1'b1)
                $display("FAIL b2b_%0d actual=%h/%b required=%h/1", i, obs, valid_o, exp_of(seq[i]));
            else n_pass++;
            n_total++;
            if ((3'(bm_s0_s0_o) + 3'(bm_s0_s2_o)) !== 3'd2 || (3'(bm_s2_s1_o) + 3'(bm_s2_s3_o)) !== 3'd2 ||
                bm_s1_s0_o !== bm_s0_s2_o || bm_s1_s2_o !== bm_s0_s0_o ||
                bm_s3_s1_o !== bm_s2_s3_o || bm_s3_s3_o !== bm_s2_s1_o)
                $display("FAIL b2b_invariant_%0d actual=%h required=consistent set", i, obs);
            else n_pass++;
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        tick();
        n_total++;
        if (valid_o !== 1'b0 || obs !== exp_of(seq[7]))
            $display("FAIL b2b_end actual=%h/%b required=%h/0", obs, valid_o, exp_of(seq[7]));
        else n_pass++;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; piso_data_i = 2'b00;
        test_reset();
        test_symbols();
        test_hold_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
